decade_counter_2d: RTL and testbench

DECADE_COUNTER_2D -- requirements
Module: decade_counter_2d

---
 rtl/decade_counter_2d_if.sv | 23 ++
 rtl/decade_counter_2d.sv | 88 ++++++++
 tb/tb_decade_counter_2d.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/decade_counter_2d_if.sv
// Control and status bundle for decade_counter_2d: the master drives load/count
// requests, the slave (the counter) returns the BCD count, terminal count and load error.
interface decade_counter_2d_if #(
  parameter int DIGITS = 2
) ();
  logic                  en;
  logic                  load;
  logic                  up;
  logic [4*DIGITS-1:0]   d_in;
  logic [4*DIGITS-1:0]   count;
  logic                  tc;
  logic                  load_err;

  modport master (
    output en, load, up, d_in,
    input  count, tc, load_err
  );

  modport slave (
    input  en, load, up, d_in,
    output count, tc, load_err
  );
endinterface

// File: rtl/decade_counter_2d.sv
// Cascaded BCD counter updating on the falling edge of clk, with validated parallel load.
// Define DECADE_COUNTER_DOWN_EN to enable down counting selected by bus.up.
module decade_counter_2d #(
  parameter int DIGITS = 2
) (
  input  logic               clk,
  input  logic               reset,
  decade_counter_2d_if.slave bus
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0]      r_count;
  logic              r_load_err;
  logic [W-1:0]      w_count_next;
  logic [DIGITS-1:0] w_nib_bad;
  logic [DIGITS:0]   w_lo9;
  logic              w_load_bad;
  logic              w_tc_hit;

  // w_lo9[k] is the carry into digit k: every digit below k currently holds 9
  assign w_lo9[0] = 1'b1;

`ifdef DECADE_COUNTER_DOWN_EN
  logic [DIGITS:0] w_lo0;
  logic            w_dir_up;

  assign w_lo0[0] = 1'b1;
  assign w_dir_up = bus.up;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] w_dig;
      logic [3:0] w_up_val;

      assign w_dig          = r_count[4*gi +: 4];
      assign w_nib_bad[gi]  = (bus.d_in[4*gi +: 4] > 4'd9);
      assign w_lo9[gi+1]    = w_lo9[gi] & (w_dig == 4'd9);
      assign w_up_val       = w_lo9[gi] ? ((w_dig == 4'd9) ? 4'd0 : w_dig + 4'd1) : w_dig;

`ifdef DECADE_COUNTER_DOWN_EN
      logic [3:0] w_dn_val;

      assign w_lo0[gi+1]    = w_lo0[gi] & (w_dig == 4'd0);
      assign w_dn_val       = w_lo0[gi] ? ((w_dig == 4'd0) ? 4'd9 : w_dig - 4'd1) : w_dig;
      assign w_count_next[4*gi +: 4] = w_dir_up ? w_up_val : w_dn_val;
`else
      assign w_count_next[4*gi +: 4] = w_up_val;
`endif
    end
  endgenerate

  assign w_load_bad = |w_nib_bad;

`ifdef DECADE_COUNTER_DOWN_EN
  assign w_tc_hit = w_dir_up ? w_lo9[DIGITS] : w_lo0[DIGITS];
`else
  logic w_unused_up;
  assign w_unused_up = bus.up;
  assign w_tc_hit    = w_lo9[DIGITS];
`endif

  // Combinational so a downstream instance on the same edge sees the carry in time
  assign bus.tc       = bus.en & ~bus.load & w_tc_hit;
  assign bus.count    = r_count;
  assign bus.load_err = r_load_err;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_load_err <= 1'b0;
    end else if (bus.load) begin
      // A rejected load also swallows en for this edge
      if (w_load_bad) begin
        r_load_err <= 1'b1;
      end else begin
        r_count    <= bus.d_in;
        r_load_err <= 1'b0;
      end
    end else begin
      r_load_err <= 1'b0;
      if (bus.en) begin
        r_count <= w_count_next;
      end
    end
  end
endmodule

// File: tb/tb_decade_counter_2d.sv
// Self-checking bench for decade_counter_2d: vector table, reset corner cases,
// full-range run and a two-instance cascade; expected results go through a queue.
module tb_decade_counter_2d;
  localparam int DIGITS = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  decade_counter_2d_if #(.DIGITS(DIGITS)) b1 ();
  decade_counter_2d_if #(.DIGITS(DIGITS)) b2 ();

  decade_counter_2d #(.DIGITS(DIGITS)) u_lo (.clk(clk), .reset(reset), .bus(b1.slave));
  decade_counter_2d #(.DIGITS(DIGITS)) u_hi (.clk(clk), .reset(reset), .bus(b2.slave));

  assign b2.en = b1.tc;

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic       en;
    logic       up;
    logic [7:0] din;
    logic [7:0] cnt;
    logic       err;
    logic       tc;
  } vec_t;

  typedef struct {
    logic [7:0] cnt;
    logic       err;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  vec_t vt[13];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Drive one cycle, check tc before the edge, queue the post-edge expectation
  task automatic step(input logic ld, input logic en, input logic upv, input logic [7:0] din,
                      input logic [7:0] cnt, input logic err, input logic tc, input string name);
    exp_t e;
    b1.load = ld;
    b1.en   = en;
    b1.up   = upv;
    b1.d_in = din;
    #1;
    check({name, ".tc"}, 32'(b1.tc), 32'(tc));
    exp_q.push_back('{cnt, err, name});
    @(negedge clk);
    #1;
    e = exp_q.pop_front();
    check({e.name, ".count"}, 32'(b1.count), 32'(e.cnt));
    check({e.name, ".load_err"}, 32'(b1.load_err), 32'(e.err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        ld en up  din    cnt    err tc
    vt[0]  = '{1, 0, 1, 8'h47, 8'h47, 0, 0};
    vt[1]  = '{0, 1, 1, 8'h00, 8'h48, 0, 0};
    vt[2]  = '{1, 0, 1, 8'h12, 8'h12, 0, 0};
    vt[3]  = '{1, 1, 1, 8'h3A, 8'h12, 1, 0};
    vt[4]  = '{0, 0, 1, 8'h00, 8'h12, 0, 0};
    vt[5]  = '{1, 0, 1, 8'hA0, 8'h12, 1, 0};
    vt[6]  = '{1, 0, 1, 8'h99, 8'h99, 0, 0};
    vt[7]  = '{0, 1, 1, 8'h00, 8'h00, 0, 1};
    vt[8]  = '{1, 1, 1, 8'h09, 8'h09, 0, 0};
    vt[9]  = '{0, 1, 1, 8'h00, 8'h10, 0, 0};
    vt[10] = '{0, 0, 1, 8'h00, 8'h10, 0, 0};
    vt[11] = '{1, 1, 1, 8'h99, 8'h99, 0, 0};
    vt[12] = '{0, 0, 1, 8'h99, 8'h99, 0, 0};

    b1.load = 1'b0; b1.en = 1'b0; b1.up = 1'b1; b1.d_in = '0;
    b2.load = 1'b0; b2.up = 1'b1; b2.d_in = '0;

    #1;
    check("reset.count", 32'(b1.count), 32'h00);
    check("reset.load_err", 32'(b1.load_err), 32'h0);
    check("reset.tc", 32'(b1.tc), 32'h0);

    // load/en requests during reset must be ignored
    b1.load = 1'b1; b1.d_in = 8'h33; b1.en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_hold.count", 32'(b1.count), 32'h00);
    reset = 1'b0;

    for (int i = 0; i < $size(vt); i++)
      step(vt[i].ld, vt[i].en, vt[i].up, vt[i].din, vt[i].cnt, vt[i].err, vt[i].tc,
           $sformatf("vec%0d", i));

`ifdef DECADE_COUNTER_DOWN_EN
    step(1, 0, 0, 8'h10, 8'h10, 0, 0, "dn_ld10");
    step(0, 1, 0, 8'h00, 8'h09, 0, 0, "dn_borrow");
    step(0, 1, 0, 8'h00, 8'h08, 0, 0, "dn_08");
    step(1, 0, 0, 8'h00, 8'h00, 0, 0, "dn_ld00");
    step(0, 1, 0, 8'h00, 8'h99, 0, 1, "dn_wrap");
    step(0, 1, 0, 8'h00, 8'h98, 0, 0, "dn_98");
    step(1, 0, 1, 8'h00, 8'h00, 0, 0, "up_ld00");
    step(0, 1, 1, 8'h00, 8'h01, 0, 0, "up_at00");
`else
    step(1, 0, 0, 8'h98, 8'h98, 0, 0, "upign_ld98");
    step(0, 1, 0, 8'h00, 8'h99, 0, 0, "upign_99");
    step(0, 1, 0, 8'h00, 8'h00, 0, 1, "upign_wrap");
`endif

    // asynchronous reset between edges, then load requested while held
    step(1, 0, 1, 8'h55, 8'h55, 0, 0, "rst_ld55");
    step(1, 0, 1, 8'h5F, 8'h55, 1, 0, "rst_bad5F");
    #3;
    reset = 1'b1;
    b1.load = 1'b1; b1.d_in = 8'h33; b1.en = 1'b1; b1.up = 1'b1;
    #1;
    check("async_rst.count", 32'(b1.count), 32'h00);
    check("async_rst.load_err", 32'(b1.load_err), 32'h0);
    check("async_rst.tc", 32'(b1.tc), 32'h0);
    @(negedge clk);
    #1;
    check("rst_load_ignored.count", 32'(b1.count), 32'h00);
    #3;
    reset = 1'b0;
    b1.load = 1'b0;
    @(negedge clk);
    #1;
    check("first_edge.count", 32'(b1.count), 32'h01);

    // full-range up run from a fresh reset
    #1;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    check("run_reset.count", 32'(b1.count), 32'h00);
    for (int v = 0; v < 100; v++)
      step(0, 1, 1, 8'h00, to_bcd((v + 1) % 100), 0, (v == 99), $sformatf("run%0d", v));

    // cascade: high instance advances only on the low instance's tc
    #1;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    step(1, 0, 1, 8'h99, 8'h99, 0, 0, "casc_ld99");
    check("casc_before", 32'({b2.count, b1.count}), 32'h0099);
    step(0, 1, 1, 8'h00, 8'h00, 0, 1, "casc_edge");
    check("casc_after", 32'({b2.count, b1.count}), 32'h0100);
    step(0, 1, 1, 8'h00, 8'h01, 0, 0, "casc_hold");
    check("casc_hi_hold", 32'(b2.count), 32'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
